// File: rtl/if_fetch_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {IDLE, FETCH, BUF, DISCARD} state_e;
   localparam word_t NOP_INSTR = 32'h0000_0013;
   localparam word_t RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory req/ack bus between fetch (master) and memory (slave).
interface if_fetch_unit_if;
   import fetch_pkg::*;
   logic  imem_req;
   word_t imem_addr;
   logic  imem_ack;
   word_t imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry {addr, instr, valid} holding register; clear wins over load.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load_i,
   input  logic  clear_i,
   input  word_t addr_i,
   input  word_t instr_i,
   output word_t addr_o,
   output word_t instr_o,
   output logic  valid_o
);
   word_t addr_q, instr_q;
   logic  valid_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         addr_q  <= addr_i;
         instr_q <= instr_i;
         valid_q <= 1'b1;
      end
   end
   assign addr_o  = addr_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and IF/ID writer; fetches over req/ack, honours stall and redirect.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   PC_write,
   input  logic                   PCSrc,
   input  word_t                  PC_branch,
   if_fetch_unit_if.master        imem,
   output word_t                  PC_IF,
   output word_t                  INSTR_IF,
   output logic                   IF_valid
);
   state_e state_q, state_d;
   word_t  pc_q, pc_d, kill_q, kill_d, pc_if_q, pc_if_d, instr_q, instr_d;
   logic   valid_q, valid_d;
   word_t  buf_addr, buf_instr;
   logic   buf_valid, buf_load, buf_clear;
   logic   slot_free, ack, fetch_ack, slot_from_mem, slot_from_buf;
   assign slot_free = !valid_q || PC_write;
   assign ack = imem.imem_ack && (state_q == FETCH || state_q == DISCARD);
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end
   // An outstanding request is never abandoned: redirect without ack parks in DISCARD.
   always_comb begin
      state_d = PCSrc ? (((state_q == FETCH || state_q == DISCARD) && !ack) ? DISCARD : FETCH)
              : state_q == IDLE  ? FETCH
              : state_q == FETCH ? ((ack && !slot_free) ? BUF : FETCH)
              : state_q == BUF   ? (PC_write ? FETCH : BUF)
              : (ack ? FETCH : DISCARD);
   end
   always_comb begin
      imem.imem_req  = state_q == FETCH || state_q == DISCARD;
      imem.imem_addr = state_q == DISCARD ? kill_q : pc_q;
   end
   always_comb begin
      fetch_ack     = state_q == FETCH && ack && !PCSrc;
      slot_from_mem = fetch_ack && slot_free;
      slot_from_buf = state_q == BUF && buf_valid && PC_write && !PCSrc;
      buf_load      = fetch_ack && !slot_free;
      buf_clear     = PCSrc || slot_from_buf;
      pc_d          = PCSrc ? PC_branch : fetch_ack ? pc_q + 32'd4 : pc_q;
      kill_d        = (PCSrc && state_q == FETCH && !ack) ? pc_q : kill_q;
      pc_if_d       = slot_from_mem ? pc_q : slot_from_buf ? buf_addr : pc_if_q;
      instr_d       = slot_from_mem ? imem.imem_rdata : slot_from_buf ? buf_instr
                    : (PCSrc || PC_write) ? NOP_INSTR : instr_q;
      valid_d       = slot_from_mem || slot_from_buf || (valid_q && !PCSrc && !PC_write);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         kill_q  <= RESET_PC;
         pc_if_q <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         pc_if_q <= pc_if_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end
   fetch_skid_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .addr_i  (pc_q),
      .instr_i (imem.imem_rdata),
      .addr_o  (buf_addr),
      .instr_o (buf_instr),
      .valid_o (buf_valid)
   );
   assign PC_IF    = pc_if_q;
   assign INSTR_IF = instr_q;
   assign IF_valid = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios against a latency-configurable memory model.
module tb_if_fetch_unit;
   import fetch_pkg::*;
   logic  clk, reset, PC_write, PCSrc;
   word_t PC_branch, PC_IF, INSTR_IF;
   logic  IF_valid;
   int    lat, cnt, n_cmp, n_bad;
   if_fetch_unit_if bus();
   if_fetch_unit dut (
      .clk(clk), .reset(reset), .PC_write(PC_write), .PCSrc(PCSrc), .PC_branch(PC_branch),
      .imem(bus), .PC_IF(PC_IF), .INSTR_IF(INSTR_IF), .IF_valid(IF_valid)
   );
   function automatic word_t mem_word(input word_t a);
      return a ^ 32'hC0DE_0000;
   endfunction
   always_comb begin
      bus.imem_ack   = bus.imem_req && (cnt >= lat);
      bus.imem_rdata = mem_word(bus.imem_addr);
   end
   always @(posedge clk) begin
      if (reset) cnt <= 0;
      else if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
      else cnt <= 0;
   end
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      reset = 1; PC_write = 1; PCSrc = 0; PC_branch = '0; lat = 0;
      step; step;
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
      n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.imem_addr); end
      n_cmp++; if (PC_IF !== 32'h0) begin n_bad++; $display("FAIL rst_pcif got %h want 0", PC_IF); end
      n_cmp++; if (INSTR_IF !== NOP_INSTR) begin n_bad++; $display("FAIL rst_instr got %h want %h", INSTR_IF, NOP_INSTR); end
      n_cmp++; if (IF_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", IF_valid); end
   endtask
   task automatic test_stream;
      reset = 0;
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req got %b want 0", bus.imem_req); end
      step;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
      for (int a = 0; a <= 8; a += 4) begin
         step;
         n_cmp++; if (PC_IF !== a || INSTR_IF !== mem_word(a) || IF_valid !== 1'b1) begin n_bad++; $display("FAIL stream got %h/%h/%b want %h/%h/1", PC_IF, INSTR_IF, IF_valid, a, mem_word(a)); end
      end
   endtask
   task automatic test_stall;
      PC_write = 0;
      repeat (3) begin
         step;
         n_cmp++; if (PC_IF !== 32'h8 || IF_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL stall got %h/%b/%b want 8/1/0", PC_IF, IF_valid, bus.imem_req); end
      end
      PC_write = 1;
      step;
      n_cmp++; if (PC_IF !== 32'hC || INSTR_IF !== mem_word(32'hC)) begin n_bad++; $display("FAIL unstall0 got %h/%h want c/%h", PC_IF, INSTR_IF, mem_word(32'hC)); end
      step;
      n_cmp++; if (PC_IF !== 32'h10 || IF_valid !== 1'b1) begin n_bad++; $display("FAIL unstall1 got %h/%b want 10/1", PC_IF, IF_valid); end
   endtask
   task automatic test_redirect_latency;
      PCSrc = 1; PC_branch = 32'h20;
      step;
      lat = 3; PC_branch = 32'h100;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || IF_valid !== 1'b0) begin n_bad++; $display("FAIL req20 got %b/%h/%b want 1/20/0", bus.imem_req, bus.imem_addr, IF_valid); end
      step;
      PCSrc = 0;
      n_cmp++; if (bus.imem_addr !== 32'h20 || IF_valid !== 1'b0) begin n_bad++; $display("FAIL discard0 got %h/%b want 20/0", bus.imem_addr, IF_valid); end
      step;
      n_cmp++; if (bus.imem_addr !== 32'h20 || bus.imem_req !== 1'b1) begin n_bad++; $display("FAIL discard1 got %h/%b want 20/1", bus.imem_addr, bus.imem_req); end
      step;
      n_cmp++; if (bus.imem_addr !== 32'h20 || bus.imem_ack !== 1'b1) begin n_bad++; $display("FAIL discard2 got %h/%b want 20/1", bus.imem_addr, bus.imem_ack); end
      step;
      n_cmp++; if (bus.imem_addr !== 32'h100 || IF_valid !== 1'b0) begin n_bad++; $display("FAIL req100 got %h/%b want 100/0", bus.imem_addr, IF_valid); end
      for (int i = 0; i < 20 && !IF_valid; i++) step;
      n_cmp++; if (IF_valid !== 1'b1 || PC_IF !== 32'h100 || INSTR_IF !== mem_word(32'h100)) begin n_bad++; $display("FAIL target100 got %b/%h/%h want 1/100/%h", IF_valid, PC_IF, INSTR_IF, mem_word(32'h100)); end
   endtask
   task automatic test_flush_full;
      lat = 0; PCSrc = 1; PC_branch = 32'h40;
      step;
      PCSrc = 0;
      step;
      PC_write = 0;
      step;
      n_cmp++; if (PC_IF !== 32'h40 || IF_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL full got %h/%b/%b want 40/1/0", PC_IF, IF_valid, bus.imem_req); end
      PCSrc = 1; PC_branch = 32'h200;
      step;
      PCSrc = 0;
      n_cmp++; if (IF_valid !== 1'b0 || INSTR_IF !== NOP_INSTR) begin n_bad++; $display("FAIL flush got %b/%h want 0/%h", IF_valid, INSTR_IF, NOP_INSTR); end
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_bad++; $display("FAIL flush_req got %b/%h want 1/200", bus.imem_req, bus.imem_addr); end
      step;
      n_cmp++; if (PC_IF !== 32'h200 || IF_valid !== 1'b1 || INSTR_IF !== mem_word(32'h200)) begin n_bad++; $display("FAIL tgt200 got %h/%b/%h want 200/1/%h", PC_IF, IF_valid, INSTR_IF, mem_word(32'h200)); end
      PC_write = 1;
      step;
      n_cmp++; if (PC_IF !== 32'h204) begin n_bad++; $display("FAIL after200 got %h want 204", PC_IF); end
   endtask
   task automatic test_reset_discard;
      lat = 3; PCSrc = 1; PC_branch = 32'h300;
      step;
      PCSrc = 0; reset = 1;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h208) begin n_bad++; $display("FAIL in_discard got %b/%h want 1/208", bus.imem_req, bus.imem_addr); end
      step;
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || IF_valid !== 1'b0 || INSTR_IF !== NOP_INSTR) begin n_bad++; $display("FAIL rst_discard got %b/%h/%b/%h want 0/0/0/%h", bus.imem_req, bus.imem_addr, IF_valid, INSTR_IF, NOP_INSTR); end
      reset = 0; lat = 0;
      step;
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL restart got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
      step;
      n_cmp++; if (PC_IF !== 32'h0 || IF_valid !== 1'b1) begin n_bad++; $display("FAIL restart_slot got %h/%b want 0/1", PC_IF, IF_valid); end
   endtask
   task automatic test_wrap;
      PCSrc = 1; PC_branch = 32'hFFFF_FFFC;
      step;
      PCSrc = 0;
      n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req got %h want fffffffc", bus.imem_addr); end
      step;
      n_cmp++; if (PC_IF !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap got %h/%h want fffffffc/0", PC_IF, bus.imem_addr); end
      step;
      n_cmp++; if (PC_IF !== 32'h0 || INSTR_IF !== mem_word(32'h0)) begin n_bad++; $display("FAIL wrap_slot got %h/%h want 0/%h", PC_IF, INSTR_IF, mem_word(32'h0)); end
   endtask
   initial begin
      n_cmp = 0; n_bad = 0;
      test_reset;
      test_stream;
      test_stall;
      test_redirect_latency;
      test_flush_full;
      test_reset_discard;
      test_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: owns the program counter, issues requests to instruction memory over a req/ack handshake, and produces the `PC_IF` / `INSTR_IF` pair loaded by the IF/ID pipeline register. It is the writer side of that register. It honours the hazard unit's `PC_write` stall and EX-stage redirects (`PCSrc`), and tolerates variable memory latency. Up to two fetched instructions are held: the output slot plus a one-entry buffer.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, 32'h0000_0013: encoding driven on `INSTR_IF` when no valid instruction is held.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `PC_write` in 1: 1 means the slot is consumed at this edge (IF/ID loads); 0 means stall.
- `PCSrc` in 1: redirect request from EX.
- `PC_branch` in 32: redirect target, valid when `PCSrc`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, stable while `imem_req`=1 and until ack.
- `imem_ack` in 1: `imem_rdata` valid this cycle. Only meaningful while `imem_req`=1; same-cycle ack is legal.
- `imem_rdata` in 32: instruction word.
- `PC_IF` out 32: address of held instruction.
- `INSTR_IF` out 32: held instruction, or `NOP_INSTR` when invalid.
- `IF_valid` out 1: slot holds a real instruction.

## Operation
- Registers: `pc` (next fetch address), slot {`PC_IF`, `INSTR_IF`, `IF_valid`}, buffer {addr, instr, valid}, `kill_addr`, state.
- `slot_free` = !`IF_valid` || `PC_write`.
- States:
  - IDLE: `imem_req`=0; next state FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. On ack with `slot_free`: slot loads {`pc`, rdata, 1}, `pc`+=4, stay in FETCH. On ack without `slot_free`: buffer loads {`pc`, rdata}, `pc`+=4, go to BUF. No ack: stay.
  - BUF: `imem_req`=0. When `PC_write`=1: slot loads from the buffer, buffer clears, go to FETCH.
  - DISCARD: `imem_req`=1, `imem_addr`=`kill_addr`. On ack: data dropped, go to FETCH.
- Slot consumed with nothing to load (FETCH, no ack, `PC_write`=1): `IF_valid` goes to 0, `INSTR_IF` goes to `NOP_INSTR`, `PC_IF` holds.
- Redirect (`PCSrc`=1) beats everything except reset:
  - Slot and buffer are invalidated; `pc` takes `PC_branch`.
  - FETCH without ack: `kill_addr` takes `pc`, go to DISCARD. The outstanding request is never abandoned.
  - DISCARD without ack: stay in DISCARD, `kill_addr` unchanged.
  - DISCARD with ack, or FETCH with ack, or BUF or IDLE: go to FETCH. Ack data dropped.
- `PCSrc`=1 with `PC_write`=0 in the same cycle: flush still applies.
- PC arithmetic is modulo 2^32; `pc`+4 wraps 32'hFFFF_FFFC to 0. Low two address bits are passed through unchecked.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `kill_addr`=`RESET_PC`, `PC_IF`=0, `INSTR_IF`=`NOP_INSTR`, `IF_valid`=0, buffer invalid.
- `imem_req`=0 and `imem_addr`=`RESET_PC` during and immediately after reset.
- Reset in any state, including DISCARD with a request outstanding, returns to IDLE. The memory is reset by the same `reset`, so no stale ack follows.
- `imem_req` and `imem_addr` are decoded from registered state only, never from inputs.
- Latency: ack at edge N puts the instruction on `PC_IF`/`INSTR_IF` from cycle N+1.
- With zero-wait memory and `PC_write`=1, sustained throughput is one instruction per cycle.
- Redirect penalty: the first target instruction is valid 2 cycles after `PCSrc`, assuming a zero-wait ack in the next cycle, plus the remaining latency of any discarded request.

## Structure
- Package `fetch_pkg`: state enum {IDLE, FETCH, BUF, DISCARD}, `NOP_INSTR` constant, `RESET_PC` default, 32-bit word type.
- One sub-module, `fetch_skid_buf`: 1-entry {addr, instr, valid} register with load and clear. It is instantiated for the buffer.

## Test plan
1. `RESET_PC`=0, zero-wait memory, `PC_write`=1 after reset release: `imem_req` rises on the 2nd cycle. `PC_IF` reads 0, 4, 8, 12 on consecutive cycles with `INSTR_IF` equal to mem[addr>>2].
2. `PC_write`=0 for 3 cycles while `PC_IF`=8: slot holds 8, buffer takes 12, `imem_req`=0. On release, `PC_IF` reads 12, then 16, with no duplicate and no gap.
3. 3-cycle memory latency, `PCSrc`=1 with `PC_branch`=0x100 one cycle after the request for 0x20: `IF_valid` goes to 0. `imem_addr` stays 0x20 until ack; that data is dropped. Next request is 0x100, followed by `PC_IF`=0x100 with `IF_valid`=1.
4. Slot and buffer both full (`PC_IF`=0x40, buffer 0x44), `PCSrc`=1 with target 0x200 and `PC_write`=0: both are cleared. `INSTR_IF`=`NOP_INSTR`, and the next valid `PC_IF` is 0x200.
5. `reset` asserted in DISCARD: the next cycle is IDLE with `imem_req`=0, `pc`=`RESET_PC`, `IF_valid`=0, and the fetch restarts at `RESET_PC`.
6. `pc`=32'hFFFF_FFFC with zero-wait memory: the following fetch address is 0.
